scan_key_guard: RTL and testbench



---
 rtl/scan_guard_pkg.sv | 22 ++
 rtl/scan_key_sreg.sv | 25 ++
 rtl/scan_key_guard.sv | 159 +++++++++++++++
 tb/tb_scan_key_guard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_guard_pkg.sv
// Shared types and sizing helpers for the scan key guard.
// State encoding plus total-length and counter-width functions.
package scan_guard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOCKOUT
  } state_t;

  // Shifts in a full session: core chain plus key segment.
  function automatic int total_len(input int chain_len, input int key_width);
    return chain_len + key_width;
  endfunction

  // Counter must hold TOTAL+1 (overlong marker).
  function automatic int cnt_width(input int total);
    return $clog2(total + 2);
  endfunction

endpackage

// File: rtl/scan_key_sreg.sv
// Generic key segment shift register: serial in at bit 0, out at MSB.
// Parallel view of the held bits; asynchronous active-high clear.
module scan_key_sreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q
);

  // Shift toward the MSB when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/scan_key_guard.sv
// Scan access guard: counts session shifts, checks the tail key at close.
// Optional failed-attempt lockout enabled by SCAN_KEY_LOCKOUT_EN.
module scan_key_guard
  import scan_guard_pkg::*;
#(
  parameter int                   CHAIN_LEN = 152,
  parameter int                   KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] KEY       = 16'hA5C3,
  parameter int                   MAX_FAILS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_enable,
  input  logic scan_in,
  input  logic halt_in,
  input  logic chain_out,
  input  logic proc_en_req,
  output logic chain_in,
  output logic chain_shift,
  output logic scan_out,
  output logic proc_en,
  output logic unlocked,
  output logic key_fail
);

  localparam int TOTAL = total_len(CHAIN_LEN, KEY_WIDTH);
  localparam int CW    = cnt_width(TOTAL);
  localparam logic [CW-1:0] TOT_C = CW'(TOTAL);
  localparam logic [CW-1:0] SAT_C = CW'(TOTAL + 1);

  if (KEY_WIDTH < 2) begin : g_bad_key
    $error("KEY_WIDTH must be at least 2");
  end
  if (MAX_FAILS < 1) begin : g_bad_fails
    $error("MAX_FAILS must be at least 1");
  end

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  unlocked_n;
  logic                  key_fail_n;
  logic                  key_msb;
  logic [KEY_WIDTH-1:0]  key_q;
  logic                  pass;

`ifdef SCAN_KEY_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] MAX_C = FW'(MAX_FAILS);
  logic [FW-1:0] fail_cnt, fail_n, fail_inc;
`endif

  assign chain_in    = scan_in;
  assign chain_shift = scan_enable & (state != LOCKOUT);
  assign scan_out    = scan_enable ? (unlocked & key_msb) : halt_in;
  assign proc_en     = proc_en_req & unlocked & ~scan_enable;
  assign pass        = (cnt == TOT_C) && (key_q == KEY);

  scan_key_sreg #(
    .WIDTH(KEY_WIDTH)
  ) u_key (
    .clk  (clk),
    .rst  (rst),
    .shift(chain_shift),
    .sin  (chain_out),
    .sout (key_msb),
    .q    (key_q)
  );

`ifdef SCAN_KEY_LOCKOUT_EN
  assign fail_inc = (fail_cnt == MAX_C) ? fail_cnt : fail_cnt + FW'(1);
`endif

  // Session sequencing, shift counting and verdict at session close.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    unlocked_n = unlocked;
    key_fail_n = 1'b0;
`ifdef SCAN_KEY_LOCKOUT_EN
    fail_n     = fail_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (scan_enable) begin
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (scan_enable) begin
          cnt_n = (cnt == SAT_C) ? SAT_C : cnt + CW'(1);
        end else begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (pass) begin
          unlocked_n = 1'b1;
`ifdef SCAN_KEY_LOCKOUT_EN
          fail_n     = '0;
`endif
        end else begin
          unlocked_n = 1'b0;
          key_fail_n = 1'b1;
`ifdef SCAN_KEY_LOCKOUT_EN
          fail_n     = fail_inc;
`endif
        end
        if (scan_enable) begin
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
`ifdef SCAN_KEY_LOCKOUT_EN
        if (!pass && fail_inc == MAX_C) begin
          state_n = LOCKOUT;
        end
`endif
      end
      LOCKOUT: begin
`ifdef SCAN_KEY_LOCKOUT_EN
        unlocked_n = 1'b0;
        state_n    = LOCKOUT;
`else
        state_n    = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      unlocked <= 1'b0;
      key_fail <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      unlocked <= unlocked_n;
      key_fail <= key_fail_n;
    end
  end

`ifdef SCAN_KEY_LOCKOUT_EN
  // Bad-attempt counter, cleared only by a good key or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
    end else begin
      fail_cnt <= fail_n;
    end
  end
`endif

endmodule

// File: tb/tb_scan_key_guard.sv
// Testbench for scan_key_guard with an 8-bit core chain model.
// Reference model tracks sessions as bit lists and judges them by rule.
module tb_scan_key_guard;

  localparam int CHAIN_LEN = 8;
  localparam int KEY_WIDTH = 16;
  localparam logic [15:0] KEY = 16'hA5C3;
  localparam int MAX_FAILS = 4;
  localparam int TOTAL = CHAIN_LEN + KEY_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_enable = 1'b0;
  logic scan_in = 1'b0;
  logic halt_in = 1'b0;
  logic proc_en_req = 1'b0;
  logic chain_out;
  logic chain_in, chain_shift, scan_out, proc_en, unlocked, key_fail;

  logic [CHAIN_LEN-1:0] core = '0;

  int n_tot = 0;
  int n_fail = 0;

  logic [TOTAL-1:0] m_pipe = '0;
  logic [15:0] m_key = '0;
  logic m_unl = 1'b0;
  logic m_kf = 1'b0;
  logic m_in = 1'b0;
  logic m_pend = 1'b0;
  logic m_locked = 1'b0;
  int m_len = 0;
  int m_last = 0;
  int m_fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (chain_shift) core <= {core[CHAIN_LEN-2:0], chain_in};
  assign chain_out = core[CHAIN_LEN-1];

  scan_key_guard #(
    .CHAIN_LEN(CHAIN_LEN),
    .KEY_WIDTH(KEY_WIDTH),
    .KEY(KEY),
    .MAX_FAILS(MAX_FAILS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_enable(scan_enable),
    .scan_in(scan_in),
    .halt_in(halt_in),
    .chain_out(chain_out),
    .proc_en_req(proc_en_req),
    .chain_in(chain_in),
    .chain_shift(chain_shift),
    .scan_out(scan_out),
    .proc_en(proc_en),
    .unlocked(unlocked),
    .key_fail(key_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic se, input logic sin);
    logic was_locked;
    logic ok;
    was_locked = m_locked;
    m_kf = 1'b0;
    if (m_pend) begin
      ok = (m_len == TOTAL) && (m_key == KEY);
      m_last = m_len;
      m_pend = 1'b0;
      if (ok) begin
        m_unl = 1'b1;
        m_fails = 0;
      end else begin
        m_unl = 1'b0;
        m_kf = 1'b1;
`ifdef SCAN_KEY_LOCKOUT_EN
        if (m_fails < MAX_FAILS) m_fails++;
        if (m_fails == MAX_FAILS) m_locked = 1'b1;
`endif
      end
    end
    if (se && !was_locked) begin
      m_pipe = {m_pipe[TOTAL-2:0], sin};
      if (!m_in) begin
        m_in = 1'b1;
        m_len = 0;
        m_key = '0;
      end
      if (m_len < KEY_WIDTH) m_key = {m_key[14:0], sin};
      m_len++;
    end else if (m_in && !se) begin
      m_in = 1'b0;
      m_pend = 1'b1;
    end
  endtask

  task automatic cyc(input logic se, input logic sin);
    @(negedge clk);
    scan_enable = se;
    scan_in = sin;
    halt_in = 1'($urandom);
    proc_en_req = 1'($urandom);
    #1;
    chk("chain_in", chain_in, sin);
    chk("chain_shift", chain_shift, se & ~m_locked);
    chk("scan_out", scan_out, se ? (m_unl & m_pipe[TOTAL-1]) : halt_in);
    chk("proc_en", proc_en, proc_en_req & m_unl & ~se);
    chk("unlocked", unlocked, m_unl);
    chk("key_fail", key_fail, m_kf);
    @(posedge clk);
    model_edge(se, sin);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    scan_enable = 1'b0;
    proc_en_req = 1'b1;
    #1;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_key_fail", key_fail, 0);
    chk("rst_cnt", dut.cnt, 0);
    chk("rst_proc_en", proc_en, 0);
    chk("rst_scan_out", scan_out, halt_in);
    @(negedge clk);
    rst = 1'b0;
    m_unl = 1'b0;
    m_kf = 1'b0;
    m_in = 1'b0;
    m_pend = 1'b0;
    m_locked = 1'b0;
    m_fails = 0;
    m_len = 0;
    m_pipe[TOTAL-1:CHAIN_LEN] = '0;
  endtask

  task automatic session(input logic [31:0] bits, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) cyc(1'b1, bits[i]);
    for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom));
  endtask

  initial begin
    logic [31:0] d;
    int len;
    do_reset();
    // reset state and a scan while locked
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0);
    session(32'h0, 4, 3);
    do_reset();
    // good session
    session({8'h0, KEY, 8'h3C}, 24, 3);
    chk("core_3c", core, 8'h3C);
    chk("unlock_good", unlocked, 1);
    // zeros replay previous contents then fail
    session(32'h0, 24, 3);
    chk("zeros_fail", unlocked, 0);
    // short and overlong
    session(32'({KEY, 7'h1E}), 23, 3);
    chk("short_cnt", dut.cnt, 23);
    session({8'h0, KEY, 8'h3C}, 24, 2);
    session(32'({KEY, 9'h079}), 25, 3);
    chk("long_cnt", dut.cnt, (m_last > TOTAL) ? TOTAL + 1 : m_last);
    chk("long_fail", unlocked, 0);
    // reset mid-session then full session
    session({8'h0, KEY, 8'h3C}, 24, 2);
    d = {8'h0, KEY, 8'h3C};
    for (int i = 23; i >= 14; i--) cyc(1'b1, d[i]);
    do_reset();
    session({8'h0, KEY, 8'h55}, 24, 3);
    chk("after_rst_unlock", unlocked, 1);
    // randomized sessions, some back-to-back through the check cycle
    for (int s = 0; s < 10; s++) begin
      len = 23 + int'($urandom_range(2));
      d = $urandom;
      if ($urandom_range(1) == 1) d[len-1 -: 16] = KEY;
      session(d, len, int'($urandom_range(1, 3)));
    end
    for (int g = 0; g < 2; g++) cyc(1'b0, 1'b0);
`ifdef SCAN_KEY_LOCKOUT_EN
    do_reset();
    for (int s = 0; s < MAX_FAILS; s++) session({8'h0, ~KEY, 8'h11}, 24, 2);
    session({8'h0, KEY, 8'h3C}, 24, 3);
    chk("lock_shift", chain_shift, 0);
    chk("lock_unl", unlocked, 0);
    do_reset();
    session({8'h0, KEY, 8'h3C}, 24, 3);
    chk("unlock_after_lock", unlocked, 1);
`endif
    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule
